// File: rtl/fifo_rr_arbiter_if.sv
// Handshake bundle between the round-robin drain arbiter and its FIFO bank / consumer.
// master = arbiter side, slave = FIFO bank plus downstream sink.
interface fifo_rr_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int WS      = 16
);
  logic [N_PORTS-1:0]         i_pndng;
  logic [N_PORTS*WS-1:0]      i_data;
  logic [N_PORTS-1:0]         o_pop;
  logic [WS-1:0]              o_data;
  logic                       o_valid;
  logic                       i_ready;
  logic [$clog2(N_PORTS)-1:0] o_src;

  modport master (
    input  i_pndng, i_data, i_ready,
    output o_pop, o_data, o_valid, o_src
  );

  modport slave (
    output i_pndng, i_data, i_ready,
    input  o_pop, o_data, o_valid, o_src
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain arbiter: pops one fifosc at a time and forwards the word on valid/ready.
// Optional multi-word grants are compiled in with FIFO_RR_ARBITER_BURST_EN.
module fifo_rr_arbiter #(
  parameter int N_PORTS   = 4,
  parameter int WS        = 16,
  parameter int BURST_LEN = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_fifo,
  fifo_rr_arbiter_if.master bus,
  output logic              o_busy
);
  localparam int IDX_W = $clog2(N_PORTS);
  localparam logic [N_PORTS-1:0] POP_ONE = N_PORTS'(1);

  if (N_PORTS < 2 || BURST_LEN < 1) begin : g_param_check
    $error("fifo_rr_arbiter: N_PORTS must be >= 2 and BURST_LEN >= 1");
  end

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    POP  = 2'd1,
    CAPT = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [WS-1:0]    data_q, data_d;
  logic             handshake_s;

`ifdef FIFO_RR_ARBITER_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
`endif

  // First requester strictly after `last`, wrapping around the port range.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_PORTS-1:0] req,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] sel;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= N_PORTS; i++) begin
      sel = IDX_W'((int'(last) + i) % N_PORTS);
      if (!found && req[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end
    return pick;
  endfunction

  assign handshake_s  = (state_q == SEND) && bus.i_ready;
  assign bus.o_pop    = (state_q == POP) ? (POP_ONE << grant_q) : '0;
  assign bus.o_valid  = (state_q == SEND);
  assign bus.o_data   = data_q;
  assign bus.o_src    = grant_q;
  assign o_busy       = (state_q != ARB);

  // Next-state and datapath selection for the ARB/POP/CAPT/SEND sequence.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
`ifdef FIFO_RR_ARBITER_BURST_EN
    burst_cnt_d  = burst_cnt_q;
`endif
    case (state_q)
      ARB: begin
        if (|bus.i_pndng) begin
          grant_d = rr_pick(bus.i_pndng, last_grant_q);
          state_d = POP;
        end else begin
          state_d = ARB;
        end
      end
      POP: begin
        state_d = CAPT;
      end
      CAPT: begin
        // FIFO output is registered, so the popped word is visible only now.
        data_d       = bus.i_data[int'(grant_q)*WS +: WS];
        last_grant_d = grant_q;
        state_d      = SEND;
      end
      SEND: begin
        if (handshake_s) begin
`ifdef FIFO_RR_ARBITER_BURST_EN
          if (bus.i_pndng[grant_q] && ((int'(burst_cnt_q) + 1) < BURST_LEN)) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
            state_d     = POP;
          end else begin
            burst_cnt_d = '0;
            state_d     = ARB;
          end
`else
          state_d = ARB;
`endif
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // State, grant and output word registers.
  always_ff @(posedge i_clk or posedge i_reset_fifo) begin
    if (i_reset_fifo) begin
      state_q      <= ARB;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(N_PORTS - 1);
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
    end
  end

`ifdef FIFO_RR_ARBITER_BURST_EN
  // Words taken under the current grant.
  always_ff @(posedge i_clk or posedge i_reset_fifo) begin
    if (i_reset_fifo) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: behavioural FIFO bank, scoreboard of expected {src,data} words,
// table-driven single-requester vectors and hand-written multi-cycle sequences.
module tb_fifo_rr_arbiter;
  localparam int N  = 4;
  localparam int WS = 16;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst;
  logic ready;
  logic busy;
  logic [N-1:0]  load_mask;
  logic [WS-1:0] load_data [N];
  logic [N-1:0]  pndng;
  logic [WS-1:0] dout [N];
  logic [WS-1:0] mem [N][32];
  logic [4:0]    wp [N];
  logic [4:0]    rp [N];

  int checks  = 0;
  int errors  = 0;
  int pop_cnt = 0;

  typedef struct {
    logic [1:0]    src;
    logic [WS-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int            port;
    logic [WS-1:0] data;
    logic [N-1:0]  pop;
  } vec_t;
  vec_t vecs [5];

  fifo_rr_arbiter_if #(.N_PORTS(N), .WS(WS)) bus ();

  fifo_rr_arbiter #(.N_PORTS(N), .WS(WS), .BURST_LEN(BL)) dut (
    .i_clk        (clk),
    .i_reset_fifo (rst),
    .bus          (bus),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  assign bus.i_pndng = pndng;
  assign bus.i_ready = ready;
  assign bus.i_data  = {dout[3], dout[2], dout[1], dout[0]};

  // Behavioural fifosc bank: registered data out, pop ignored when empty.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        wp[k]   <= 5'd0;
        rp[k]   <= 5'd0;
        dout[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (load_mask[k]) begin
          mem[k][wp[k]] <= load_data[k];
          wp[k]         <= wp[k] + 5'd1;
        end
        if (bus.o_pop[k] && (wp[k] != rp[k])) begin
          dout[k] <= mem[k][rp[k]];
          rp[k]   <= rp[k] + 5'd1;
        end
      end
    end
  end

  always_comb begin
    pndng = '0;
    for (int k = 0; k < N; k++) pndng[k] = (wp[k] != rp[k]);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Pop legality and scoreboard comparison of every completed handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_pop != '0) begin
        pop_cnt++;
        check("pop_onehot", 32'($countones(bus.o_pop)), 32'd1);
        for (int k = 0; k < N; k++)
          if (bus.o_pop[k]) check("pop_safe", 32'(pndng[k]), 32'd1);
      end
      if (bus.o_valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word got src=%0d data=%0h exp=none", bus.o_src, bus.o_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_src", 32'(bus.o_src), 32'(e.src));
          check("sb_data", 32'(bus.o_data), 32'(e.data));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_load(input logic [N-1:0] m);
    load_mask = m;
    step();
    load_mask = '0;
  endtask

  task automatic load1(input int port, input logic [WS-1:0] d);
    load_data[port] = d;
    apply_load(N'(1) << port);
  endtask

  task automatic expect_word(input int src, input logic [WS-1:0] d);
    exp_t e;
    e.src  = 2'(src);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL drain_timeout got pending=%0d busy=%0b exp pending=0 busy=0", exp_q.size(), busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    int n;
    ready     = 1'b1;
    load_mask = '0;
    for (int k = 0; k < N; k++) load_data[k] = '0;
    rst = 1'b1;
    step();
    step();
    check("rst_pop",   32'(bus.o_pop),   32'd0);
    check("rst_data",  32'(bus.o_data),  32'd0);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_src",   32'(bus.o_src),   32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    rst = 1'b0;
    step();

    // Single requester: exact cycle-by-cycle pop/valid timing.
    vecs[0] = '{2, 16'hA5A5, 4'b0100};
    vecs[1] = '{2, 16'h5A5A, 4'b0100};
    vecs[2] = '{0, 16'h0F0F, 4'b0001};
    vecs[3] = '{3, 16'hC3C3, 4'b1000};
    vecs[4] = '{1, 16'h7E7E, 4'b0010};
    for (int v = 0; v < 5; v++) begin
      expect_word(vecs[v].port, vecs[v].data);
      load1(vecs[v].port, vecs[v].data);
      check("v_pop_pre",  32'(bus.o_pop),   32'd0);
      check("v_busy_pre", 32'(busy),        32'd0);
      step();
      check("v_pop",      32'(bus.o_pop),   32'(vecs[v].pop));
      check("v_busy",     32'(busy),        32'd1);
      step();
      check("v_pop_capt", 32'(bus.o_pop),   32'd0);
      check("v_val_capt", 32'(bus.o_valid), 32'd0);
      step();
      check("v_valid",    32'(bus.o_valid), 32'd1);
      check("v_data",     32'(bus.o_data),  32'(vecs[v].data));
      check("v_src",      32'(bus.o_src),   32'(vecs[v].port));
      step();
      check("v_valid_end", 32'(bus.o_valid), 32'd0);
      check("v_busy_end",  32'(busy),        32'd0);
    end

    // All four loaded right after reset: served 0,1,2,3.
    rst = 1'b1;
    step();
    rst = 1'b0;
    pc = pop_cnt;
    for (int k = 0; k < N; k++) begin
      load_data[k] = WS'(16'h1000 + k);
      expect_word(k, WS'(16'h1000 + k));
    end
    apply_load(4'b1111);
    wait_drain(80);
    check("all4_pops", 32'(pop_cnt - pc), 32'd4);

    // Wrap-around: last_grant=1, then ports 3 and 1 pending -> 3 then 1.
    expect_word(1, 16'h1111);
    load1(1, 16'h1111);
    wait_drain(40);
    load_data[3] = 16'h3333;
    load_data[1] = 16'h1112;
    expect_word(3, 16'h3333);
    expect_word(1, 16'h1112);
    apply_load(4'b1010);
    wait_drain(60);

    // Backpressure: SEND held for 10 cycles.
    ready = 1'b0;
    expect_word(0, 16'hBEEF);
    load1(0, 16'hBEEF);
    n = 0;
    while (!bus.o_valid && n < 20) begin
      step();
      n++;
    end
    check("bp_valid_seen", 32'(bus.o_valid), 32'd1);
    pc = pop_cnt;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(bus.o_valid), 32'd1);
      check("bp_data",  32'(bus.o_data),  32'hBEEF);
      check("bp_src",   32'(bus.o_src),   32'd0);
      check("bp_pop",   32'(bus.o_pop),   32'd0);
      step();
    end
    check("bp_no_pop", 32'(pop_cnt - pc), 32'd0);
    ready = 1'b1;
    step();
    check("bp_delivered", 32'(bus.o_valid), 32'd0);
    check("bp_sb_empty",  32'(exp_q.size()), 32'd0);

    // Reset during CAPT discards the word; port 0 then has priority.
    load1(1, 16'h5555);
    step();
    step();
    check("rc_busy_capt",  32'(busy),        32'd1);
    check("rc_valid_capt", 32'(bus.o_valid), 32'd0);
    rst = 1'b1;
    step();
    check("rc_pop",   32'(bus.o_pop),   32'd0);
    check("rc_data",  32'(bus.o_data),  32'd0);
    check("rc_valid", 32'(bus.o_valid), 32'd0);
    check("rc_src",   32'(bus.o_src),   32'd0);
    check("rc_busy",  32'(busy),        32'd0);
    rst = 1'b0;
    load_data[0] = 16'h6000;
    load_data[1] = 16'h6001;
    expect_word(0, 16'h6000);
    expect_word(1, 16'h6001);
    apply_load(4'b0011);
    wait_drain(60);

    // Port 0 with six words, port 1 with one.
    rst = 1'b1;
    step();
    rst = 1'b0;
`ifdef FIFO_RR_ARBITER_BURST_EN
    for (int i = 0; i < 4; i++) expect_word(0, WS'(16'h2000 + i));
    expect_word(1, 16'h3000);
    expect_word(0, 16'h2004);
    expect_word(0, 16'h2005);
`else
    expect_word(0, 16'h2000);
    expect_word(1, 16'h3000);
    for (int i = 1; i < 6; i++) expect_word(0, WS'(16'h2000 + i));
`endif
    load_data[0] = 16'h2000;
    load_data[1] = 16'h3000;
    apply_load(4'b0011);
    for (int i = 1; i < 6; i++) begin
      load_data[0] = WS'(16'h2000 + i);
      apply_load(4'b0001);
    end
    wait_drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
